// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute/memory stage and a byte-addressed data memory.
// Aligned accesses take one memory cycle; misaligned ones are split into byte accesses or rejected.
module lsu_mem_ctrl #(
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  mem_length,
  output logic        mem_sign,
  output logic        mem_enable,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [1:0]  last_k;
  logic [31:0] rdata_ext;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;

  assign illegal = req_wr ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                          : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign last_k = f3_q[1] ? 2'd3 : 2'd1;

  // Re-extending aligned results is harmless; split results need it.
  always_comb begin
    case (f3_q)
      3'b000:  rdata_ext = {{24{data_q[7]}}, data_q[7:0]};
      3'b100:  rdata_ext = {24'h0, data_q[7:0]};
      3'b001:  rdata_ext = {{16{data_q[15]}}, data_q[15:0]};
      3'b101:  rdata_ext = {16'h0, data_q[15:0]};
      default: rdata_ext = data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    err_d       = err_q;
    k_d         = k_q;
    data_d      = data_q;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_length  = 2'b00;
    mem_sign    = 1'b0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;

    case (state_q)
      ACCESS: begin
        mem_enable  = 1'b1;
        mem_wr      = wr_q;
        mem_addr    = addr_q;
        mem_length  = f3_q[1:0];
        mem_sign    = ~f3_q[2];
        mem_data_in = wdata_q;
        if (!wr_q) data_d = mem_data_out;
        state_d = RESP;
      end
      SPLIT: begin
        mem_enable  = 1'b1;
        mem_wr      = wr_q;
        mem_addr    = addr_q + {30'h0, k_q};
        mem_data_in = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
        if (!wr_q) data_d[{k_q, 3'b000} +: 8] = mem_data_out[7:0];
        if (k_q == last_k) state_d = RESP;
        else               k_d     = k_q + 2'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || wr_q) ? '0 : rdata_ext;
        state_d   = IDLE;
      end
      default: ;
    endcase

    // Accept only happens in IDLE/RESP, so it safely overrides the hold/exit decisions above.
    if (accept) begin
      wr_d    = req_wr;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      f3_d    = req_funct3;
      k_d     = 2'd0;
      data_d  = '0;
      err_d   = 1'b0;
      if (illegal || (misaligned && (ALLOW_MISALIGNED == 0))) begin
        err_d   = 1'b1;
        state_d = RESP;
      end else if (misaligned) begin
        state_d = SPLIT;
      end else begin
        state_d = ACCESS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      k_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

endmodule
